stage3_writeback: RTL and testbench
===================================

Name: stage3_writeback

Overview:
- Final stage of the 3-stage RISC-V pipeline. Registers execute-stage results and picks writeback data from load data, ALU result or PC+4.
- Extracts and sign/zero-extends sub-word load data, undoing the byte-lane shift applied to store data in execute.
- Holds the tohost CSR and the retired-instruction and cycle counters.
- Drives the register-file write port, and returns wb_data and stage3_inst to execute for forwarding.

Parameters:
NOP_INST, 32'h00000013, instruction loaded into stage 3 on reset/kill (addi x0,x0,0)
TOHOST_ADDR, 12'h51E, CSR address of tohost

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
stall  input  1  hold stage-3 pipeline registers
kill  input  1  load a bubble (NOP_INST, invalid) into stage 3 this edge
stage2_inst_out  input  32  instruction leaving execute
stage2_pc_out  input  32  PC of that instruction
stage2_alu_out  input  32  ALU result (also dmem address)
stage2_csr_data  input  32  rs1 value of that instruction, for csrrw
dmem_dout  input  32  synchronous dmem read data, valid in the cycle after the address
stage3_inst  output  32  instruction in stage 3 (to forwarding logic)
wb_data  output  32  writeback value (to regfile and forwarding)
rf_we  output  1  register-file write enable
rf_wa  output  5  register-file write address = stage3_inst[11:7]
csr_tohost  output  32  tohost CSR value
instret  output  32  retired-instruction count
cycle  output  32  cycle count since reset

Behaviour:
- Pipeline registers (inst, pc, alu, csr_data, valid):
  - Priority rst > kill > stall > capture.
  - rst or kill: inst=NOP_INST, valid=0, pc/alu/csr_data=0.
  - stall: hold all.
  - Otherwise: capture stage2 inputs, valid=1.
- Writeback select, combinational from stage3 opcode:
  - LOAD 0000011 -> aligned load data.
  - JAL 1101111 / JALR 1100111 -> pc+4, wrapping mod 2^32.
  - All others -> alu.
- Load alignment uses off = alu[1:0]:
  - LB/LBU (funct3 000/100): byte at bits [8*off+7:8*off], sign/zero-extended.
  - LH/LHU (001/101): halfword selected by off[1] alone; off[0] ignored, no misalignment trap.
  - LW (010): whole word; off ignored.
  - Undefined funct3: whole word.
- rf_we = 1 only when opcode is LUI, AUIPC, JAL, JALR, LOAD, OP-IMM or OP, and rd != 0.
- rf_we = 0 for branch, store, SYSTEM, reset bubble and kill bubble. rf_we is not gated by stall: rewriting the same value is harmless.
- CSR: when valid, opcode 1110011, csr = inst[31:20] == TOHOST_ADDR, and not stall:
  - funct3 001: csr_tohost <= csr_data.
  - funct3 101: csr_tohost <= {27'b0, inst[19:15]}.
  - Other CSR funct3 and other addresses: no effect.
  - csr_tohost resets to 0.
- instret: +1 on each edge where valid && !stall && !rst; the same instruction is never counted twice. Wraps at 2^32. Resets to 0.
- cycle: +1 every non-reset edge, wraps, resets to 0.
- Environment contract: dmem holds dmem_dout stable while stall=1.
- All outputs are defined from the first edge with rst=1:
  - stage3_inst=NOP_INST, wb_data=0, rf_we=0, rf_wa=0.
  - csr_tohost=0, instret=0, cycle=0.
- Reset mid-operation discards the in-flight instruction with no CSR write and no count.

Decomposition:
- Package riscv_pkg: opcode constants (LOAD, OP_IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, STORE, SYSTEM), load funct3 constants, NOP_INST, TOHOST_ADDR.
- Sub-module load_align: purely combinational (dmem_dout, funct3, off -> 32-bit data).
- Pipeline registers, wb mux, CSR and counters stay in the top module.

Test Plan:
1. Reset: rst=1 two cycles -> stage3_inst=0x00000013, rf_we=0, wb_data=0, csr_tohost=0, instret=0, cycle=0; after release, cycle counts 1,2,3.
2. Load alignment, alu=0x1003, dmem_dout=0x80FF1234:
   - LB -> 0xFFFFFF80; LBU -> 0x00000080.
   - With alu=0x1002: LH -> 0xFFFF80FF; LHU -> 0x000080FF; LW -> 0x80FF1234.
3. JAL x1 at pc=0x00000100 -> wb_data=0x00000104, rf_we=1, rf_wa=1; JAL at pc=0xFFFFFFFC -> wb_data=0x00000000.
4. CSR writes:
   - csrw 0x51E with csr_data=0xDEADBEEF -> csr_tohost=0xDEADBEEF next edge.
   - csrwi 0x51E,5 -> 0x00000005.
   - csrw 0x51F -> unchanged; rf_we=0 throughout.
5. Stall/kill:
   - ADD held 3 stalled cycles -> stage3_inst constant, instret +1 total.
   - kill with ADD at input -> stage3_inst=0x13, instret unchanged.
   - kill and stall together -> bubble loaded.
6. Write-enable gating: addi x0,x0,7 -> rf_we=0; SW -> rf_we=0; BEQ -> rf_we=0; addi x5,x0,7 -> rf_we=1, rf_wa=5, wb_data=alu.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I encodings and stage-3 constants for the writeback stage.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRWI = 3'b101;

  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam logic [11:0] TOHOST_ADDR = 12'h51E;

endpackage

// File: rtl/load_align.sv
// Extracts a byte/halfword/word from the dmem read word and extends it per the load funct3.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] i_dout,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0:    w_byte = i_dout[7:0];
      2'd1:    w_byte = i_dout[15:8];
      2'd2:    w_byte = i_dout[23:16];
      default: w_byte = i_dout[31:24];
    endcase
    // Halfword lane comes from off[1] only; misaligned halves are not trapped.
    w_half = i_off[1] ? i_dout[31:16] : i_dout[15:0];
  end

  always_comb begin
    o_data = i_dout;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'h0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'h0, w_half};
      F3_LW:   o_data = i_dout;
      default: o_data = i_dout;
    endcase
  end

endmodule

// File: rtl/stage3_writeback.sv
// Stage 3 of the 3-stage pipeline: writeback register, wb mux, tohost CSR and perf counters.
module stage3_writeback
  import riscv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_kill,
  input  logic [31:0] i_stage2_inst_out,
  input  logic [31:0] i_stage2_pc_out,
  input  logic [31:0] i_stage2_alu_out,
  input  logic [31:0] i_stage2_csr_data,
  input  logic [31:0] i_dmem_dout,
  output logic [31:0] o_stage3_inst,
  output logic [31:0] o_wb_data,
  output logic        o_rf_we,
  output logic [4:0]  o_rf_wa,
  output logic [31:0] o_csr_tohost,
  output logic [31:0] o_instret,
  output logic [31:0] o_cycle
);

  logic [31:0] r_inst, r_pc, r_alu, r_csr_data;
  logic        r_valid;
  logic [31:0] r_tohost, r_instret, r_cycle;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd;
  logic [31:0] w_load_data;
  logic        w_we_op;
  logic        w_retire;

  assign w_opcode = r_inst[6:0];
  assign w_funct3 = r_inst[14:12];
  assign w_rd     = r_inst[11:7];
  assign w_retire = r_valid && !i_stall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_inst     <= NOP_INST;
      r_pc       <= '0;
      r_alu      <= '0;
      r_csr_data <= '0;
      r_valid    <= 1'b0;
      r_tohost   <= '0;
      r_instret  <= '0;
      r_cycle    <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_retire) begin
        r_instret <= r_instret + 32'd1;
        if (w_opcode == OPC_SYSTEM && r_inst[31:20] == TOHOST_ADDR) begin
          if (w_funct3 == F3_CSRRW) begin
            r_tohost <= r_csr_data;
          end else if (w_funct3 == F3_CSRRWI) begin
            r_tohost <= {27'h0, r_inst[19:15]};
          end
        end
      end
      if (i_kill) begin
        r_inst     <= NOP_INST;
        r_pc       <= '0;
        r_alu      <= '0;
        r_csr_data <= '0;
        r_valid    <= 1'b0;
      end else if (!i_stall) begin
        r_inst     <= i_stage2_inst_out;
        r_pc       <= i_stage2_pc_out;
        r_alu      <= i_stage2_alu_out;
        r_csr_data <= i_stage2_csr_data;
        r_valid    <= 1'b1;
      end
    end
  end

  load_align u_load_align (
    .i_dout   (i_dmem_dout),
    .i_funct3 (w_funct3),
    .i_off    (r_alu[1:0]),
    .o_data   (w_load_data)
  );

  always_comb begin
    o_wb_data = r_alu;
    w_we_op   = 1'b0;
    case (w_opcode)
      OPC_LOAD:           o_wb_data = w_load_data;
      OPC_JAL, OPC_JALR:  o_wb_data = r_pc + 32'd4;
      default:            o_wb_data = r_alu;
    endcase
    case (w_opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP: w_we_op = 1'b1;
      default:                                                            w_we_op = 1'b0;
    endcase
  end

  // Bubbles are NOP_INST with rd=x0, so the rd check alone suppresses their write.
  assign o_rf_we       = w_we_op && (w_rd != 5'd0);
  assign o_rf_wa       = w_rd;
  assign o_stage3_inst = r_inst;
  assign o_csr_tohost  = r_tohost;
  assign o_instret     = r_instret;
  assign o_cycle       = r_cycle;

endmodule

// File: tb/tb_stage3_writeback.sv
// Bench for stage3_writeback: directed plan steps then randomized traffic against a reference model.
module tb_stage3_writeback;

  logic        clk;
  logic        rst, stall, kill;
  logic [31:0] s2_inst, s2_pc, s2_alu, s2_csr, dout;
  logic [31:0] stage3_inst, wb_data, csr_tohost, instret, cycle;
  logic        rf_we;
  logic [4:0]  rf_wa;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Reference model state
  logic [31:0] m_inst, m_pc, m_alu, m_csr, m_tohost, m_instret, m_cycle;
  logic        m_valid;

  stage3_writeback dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_stall           (stall),
    .i_kill            (kill),
    .i_stage2_inst_out (s2_inst),
    .i_stage2_pc_out   (s2_pc),
    .i_stage2_alu_out  (s2_alu),
    .i_stage2_csr_data (s2_csr),
    .i_dmem_dout       (dout),
    .o_stage3_inst     (stage3_inst),
    .o_wb_data         (wb_data),
    .o_rf_we           (rf_we),
    .o_rf_wa           (rf_wa),
    .o_csr_tohost      (csr_tohost),
    .o_instret         (instret),
    .o_cycle           (cycle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [2:0] f3, input logic [4:0] rs1,
                                      input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] model_wb();
    logic [31:0] v;
    int unsigned off;
    off = m_alu % 4;
    if (m_inst[6:0] == 7'h03) begin
      case (m_inst[14:12])
        3'd0, 3'd4: begin
          v = (dout >> (8 * off)) & 32'hFF;
          if (m_inst[14:12] == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end
        3'd1, 3'd5: begin
          v = (off >= 2) ? (dout >> 16) : (dout & 32'hFFFF);
          if (m_inst[14:12] == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end
        default: v = dout;
      endcase
      return v;
    end
    if (m_inst[6:0] == 7'h6F || m_inst[6:0] == 7'h67) return m_pc + 32'd4;
    return m_alu;
  endfunction

  function automatic logic model_we();
    logic [6:0] op;
    op = m_inst[6:0];
    return (op == 7'h37 || op == 7'h17 || op == 7'h6F || op == 7'h67 || op == 7'h03 ||
            op == 7'h13 || op == 7'h33) && (m_inst[11:7] != 5'd0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("stage3_inst", stage3_inst, m_inst);
    chk("wb_data", wb_data, model_wb());
    chk("rf_we", {31'h0, rf_we}, {31'h0, model_we()});
    chk("rf_wa", {27'h0, rf_wa}, {27'h0, m_inst[11:7]});
    chk("csr_tohost", csr_tohost, m_tohost);
    chk("instret", instret, m_instret);
    chk("cycle", cycle, m_cycle);
  endtask

  // Apply one set of inputs, take one clock edge, advance the model, check all outputs.
  task automatic cyc(input logic r, input logic s, input logic k, input logic [31:0] inst,
                     input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] csr,
                     input logic [31:0] dd);
    rst = r; stall = s; kill = k;
    s2_inst = inst; s2_pc = pc; s2_alu = alu; s2_csr = csr; dout = dd;
    @(posedge clk);
    if (r) begin
      m_inst = 32'h13; m_pc = 0; m_alu = 0; m_csr = 0; m_valid = 0;
      m_tohost = 0; m_instret = 0; m_cycle = 0;
    end else begin
      m_cycle = m_cycle + 1;
      if (m_valid && !s) begin
        m_instret = m_instret + 1;
        if (m_inst[6:0] == 7'h73 && m_inst[31:20] == 12'h51E) begin
          if (m_inst[14:12] == 3'd1) m_tohost = m_csr;
          else if (m_inst[14:12] == 3'd5) m_tohost = {27'h0, m_inst[19:15]};
        end
      end
      if (k) begin
        m_inst = 32'h13; m_pc = 0; m_alu = 0; m_csr = 0; m_valid = 0;
      end else if (!s) begin
        m_inst = inst; m_pc = pc; m_alu = alu; m_csr = csr; m_valid = 1;
      end
    end
    #1;
    check_all();
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    logic [31:0] add_i, r32, inst, cur_dout;
    logic [6:0]  ops [10];
    logic        rs, ss, ks;

    m_inst = NOP; m_pc = 0; m_alu = 0; m_csr = 0; m_valid = 0;
    m_tohost = 0; m_instret = 0; m_cycle = 0;
    add_i = {7'h0, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};

    // Reset held two cycles, then cycle counts from 1
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0, 0, add_i, 32'h40, 32'h55, 32'h66, 32'h77);
      chk("rst_inst", stage3_inst, 32'h13);
      chk("rst_wb", wb_data, 32'h0);
      chk("rst_we", {31'h0, rf_we}, 32'h0);
      chk("rst_cycle", cycle, 32'h0);
    end
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 0, NOP, 0, 0, 0, 0);
      chk("cycle_count", cycle, i);
    end

    // Load alignment
    cyc(0, 0, 0, enc(7'h03, 5'd3, 3'd0, 5'd2, 12'h0), 32'h200, 32'h1003, 0, 32'h80FF1234);
    chk("lb", wb_data, 32'hFFFFFF80);
    cyc(0, 0, 0, enc(7'h03, 5'd3, 3'd4, 5'd2, 12'h0), 32'h204, 32'h1003, 0, 32'h80FF1234);
    chk("lbu", wb_data, 32'h00000080);
    cyc(0, 0, 0, enc(7'h03, 5'd3, 3'd1, 5'd2, 12'h0), 32'h208, 32'h1002, 0, 32'h80FF1234);
    chk("lh", wb_data, 32'hFFFF80FF);
    cyc(0, 0, 0, enc(7'h03, 5'd3, 3'd5, 5'd2, 12'h0), 32'h20C, 32'h1002, 0, 32'h80FF1234);
    chk("lhu", wb_data, 32'h000080FF);
    cyc(0, 0, 0, enc(7'h03, 5'd3, 3'd2, 5'd2, 12'h0), 32'h210, 32'h1002, 0, 32'h80FF1234);
    chk("lw", wb_data, 32'h80FF1234);

    // JAL link value and wrap
    cyc(0, 0, 0, {20'h0, 5'd1, 7'h6F}, 32'h100, 32'h0, 0, 0);
    chk("jal_wb", wb_data, 32'h104);
    chk("jal_we", {31'h0, rf_we}, 32'h1);
    chk("jal_wa", {27'h0, rf_wa}, 32'h1);
    cyc(0, 0, 0, {20'h0, 5'd1, 7'h6F}, 32'hFFFFFFFC, 32'h0, 0, 0);
    chk("jal_wrap", wb_data, 32'h0);

    // tohost writes
    cyc(0, 0, 0, enc(7'h73, 5'd0, 3'd1, 5'd1, 12'h51E), 32'h300, 0, 32'hDEADBEEF, 0);
    chk("csrw_we", {31'h0, rf_we}, 32'h0);
    cyc(0, 0, 0, NOP, 0, 0, 0, 0);
    chk("csrw", csr_tohost, 32'hDEADBEEF);
    cyc(0, 0, 0, enc(7'h73, 5'd0, 3'd5, 5'd5, 12'h51E), 32'h304, 0, 0, 0);
    cyc(0, 0, 0, enc(7'h73, 5'd0, 3'd1, 5'd1, 12'h51F), 32'h308, 0, 32'h12345678, 0);
    chk("csrwi", csr_tohost, 32'h5);
    cyc(0, 0, 0, NOP, 0, 0, 0, 0);
    chk("csrw_other", csr_tohost, 32'h5);

    // Stall holds, kill bubbles, kill beats stall
    cyc(0, 0, 0, add_i, 32'h400, 32'h9, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, NOP, 0, 0, 0, 0);
      chk("stall_hold", stage3_inst, add_i);
    end
    cyc(0, 0, 1, add_i, 32'h404, 32'h9, 0, 0);
    chk("kill", stage3_inst, 32'h13);
    cyc(0, 0, 0, add_i, 32'h408, 32'h9, 0, 0);
    cyc(0, 1, 1, add_i, 32'h40C, 32'h9, 0, 0);
    chk("kill_stall", stage3_inst, 32'h13);

    // Write-enable gating
    cyc(0, 0, 0, enc(7'h13, 5'd0, 3'd0, 5'd0, 12'd7), 32'h500, 32'd7, 0, 0);
    chk("addi_x0", {31'h0, rf_we}, 32'h0);
    cyc(0, 0, 0, {7'h0, 5'd2, 5'd1, 3'd2, 5'd4, 7'h23}, 32'h504, 32'h80, 0, 0);
    chk("sw", {31'h0, rf_we}, 32'h0);
    cyc(0, 0, 0, {7'h0, 5'd2, 5'd1, 3'd0, 5'd8, 7'h63}, 32'h508, 32'h1, 0, 0);
    chk("beq", {31'h0, rf_we}, 32'h0);
    cyc(0, 0, 0, enc(7'h13, 5'd5, 3'd0, 5'd0, 12'd7), 32'h50C, 32'd7, 0, 0);
    chk("addi_x5_we", {31'h0, rf_we}, 32'h1);
    chk("addi_x5_wa", {27'h0, rf_wa}, 32'h5);
    chk("addi_x5_wb", wb_data, 32'd7);

    // Randomized traffic
    ops = '{7'h03, 7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h23, 7'h73};
    cur_dout = $urandom();
    for (int i = 0; i < 400; i++) begin
      r32  = $urandom();
      inst = {r32[31:7], ops[$urandom_range(0, 9)]};
      if (inst[6:0] == 7'h73 && $urandom_range(0, 1) == 0) inst[31:20] = 12'h51E;
      rs = ($urandom_range(0, 59) == 0);
      ss = ($urandom_range(0, 3) == 0);
      ks = ($urandom_range(0, 7) == 0);
      if (!ss) cur_dout = $urandom();
      cyc(rs, ss, ks, inst, $urandom(), $urandom(), $urandom(), cur_dout);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
